// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display encoder.
// Optional build macro: SEVEN_SEG_ACTIVE_LOW_EN selects common-anode
// (inverted) segment drive at the output register.
package seven_seg_pkg;

    localparam int SEG_WIDTH   = 7;
    localparam int DIGIT_WIDTH = 3;

    // Bit positions of each segment within the {g,f,e,d,c,b,a} word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_WIDTH-1:0]   seg_t;
    typedef logic [DIGIT_WIDTH-1:0] digit_t;

    // Active-high whole-display constants
    localparam seg_t SEG_ALL_OFF = 7'h00;
    localparam seg_t SEG_ALL_ON  = 7'h7F;

    // Active-high glyphs for the octal digits
    localparam seg_t DIGIT_0 = 7'h3F;
    localparam seg_t DIGIT_1 = 7'h06;
    localparam seg_t DIGIT_2 = 7'h5B;
    localparam seg_t DIGIT_3 = 7'h4F;
    localparam seg_t DIGIT_4 = 7'h66;
    localparam seg_t DIGIT_5 = 7'h6D;
    localparam seg_t DIGIT_6 = 7'h7D;
    localparam seg_t DIGIT_7 = 7'h07;

    // Which source wins the segment word on a given cycle
    typedef enum logic [1:0] {
        SRC_DECODE = 2'd0,
        SRC_BLANK  = 2'd1,
        SRC_LAMP   = 2'd2
    } seg_src_e;

    // Convert an active-high pattern to the physical drive polarity.
    // Common-anode panels light a segment when its line is pulled low.
    function automatic seg_t apply_polarity(input seg_t pattern);
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
        return ~pattern;
`else
        return pattern;
`endif
    endfunction

endpackage

// File: rtl/seven_seg_digit_lut.sv
// Combinational octal digit to active-high seven-segment glyph lookup.
module seven_seg_digit_lut
    import seven_seg_pkg::*;
(
    input  logic [2:0] digit,
    output logic [6:0] pattern
);

    // Glyph lookup; the default arm keeps unknown inputs dark instead of X
    always_comb begin
        pattern = SEG_ALL_OFF;
        case (digit)
            3'd0:    pattern = DIGIT_0;
            3'd1:    pattern = DIGIT_1;
            3'd2:    pattern = DIGIT_2;
            3'd3:    pattern = DIGIT_3;
            3'd4:    pattern = DIGIT_4;
            3'd5:    pattern = DIGIT_5;
            3'd6:    pattern = DIGIT_6;
            3'd7:    pattern = DIGIT_7;
            default: pattern = SEG_ALL_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_encoder.sv
// Registered 3-bit to seven-segment encoder for one digit of the
// multiplier status display, with blank and lamp-test overrides.
// Optional build macro: SEVEN_SEG_ACTIVE_LOW_EN inverts the final
// segment word for common-anode displays; digit capture is unaffected.
module seven_segment_encoder
    import seven_seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] inp,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg_out
);

    digit_t   digit_d;
    digit_t   digit_q;
    seg_t     seg_d;
    seg_t     seg_q;
    seg_t     glyph;
    seg_src_e seg_src;

    // Decode the digit that will be held after this edge, so a fresh load
    // reaches the display with the same single cycle of latency as overrides
    seven_seg_digit_lut u_lut (
        .digit   (digit_d),
        .pattern (glyph)
    );

    // Next digit: capture on enable, otherwise hold the last captured value
    always_comb begin
        digit_d = digit_q;
        if (en) begin
            digit_d = inp;
        end
    end

    // Override priority: lamp test beats blank, blank beats the decoded glyph
    always_comb begin
        seg_src = SRC_DECODE;
        if (lamp_test) begin
            seg_src = SRC_LAMP;
        end else if (blank) begin
            seg_src = SRC_BLANK;
        end
    end

    // Select the active-high segment word and convert it to drive polarity
    always_comb begin
        seg_d = apply_polarity(glyph);
        case (seg_src)
            SRC_LAMP:   seg_d = apply_polarity(SEG_ALL_ON);
            SRC_BLANK:  seg_d = apply_polarity(SEG_ALL_OFF);
            SRC_DECODE: seg_d = apply_polarity(glyph);
            default:    seg_d = apply_polarity(SEG_ALL_OFF);
        endcase
    end

    // State registers; reset clears the digit and darkens the display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
            seg_q   <= apply_polarity(SEG_ALL_OFF);
        end else begin
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_seven_segment_encoder.sv
// Testbench for seven_segment_encoder: directed steps followed by a
// randomized run, compared against a segment-letter reference model.
// Honours SEVEN_SEG_ACTIVE_LOW_EN to match the output polarity build.
module tb_seven_segment_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] inp;
    logic       blank;
    logic       lamp_test;
    logic [6:0] seg_out;

    int checks;
    int errors;

    // Reference model state
    int         model_digit;
    logic [6:0] model_seg;

    seven_segment_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .inp       (inp),
        .blank     (blank),
        .lamp_test (lamp_test),
        .seg_out   (seg_out)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Glyph built from the list of lit segment letters for each digit
    function automatic logic [6:0] glyphOf(input int d);
        string lit;
        logic [6:0] bits;
        case (d)
            0: lit = "abcdef";
            1: lit = "bc";
            2: lit = "abdeg";
            3: lit = "abcdg";
            4: lit = "bcfg";
            5: lit = "acdfg";
            6: lit = "acdefg";
            7: lit = "abc";
            default: lit = "";
        endcase
        bits = '0;
        for (int i = 0; i < lit.len(); i++) begin
            bits[lit[i] - "a"] = 1'b1;
        end
        return bits;
    endfunction

    // Physical drive level for an active-high segment word
    function automatic logic [6:0] drive(input logic [6:0] lit_segments);
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
        return ~lit_segments;
`else
        return lit_segments;
`endif
    endfunction

    task automatic checkOutput(input string tag);
        logic [2:0] exp_digit;
        exp_digit = model_digit[2:0];
        checks++;
        assert (seg_out === model_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg_out observed %h expected %h", tag, seg_out, model_seg);
        end
        checks++;
        assert (dut.digit_q === exp_digit) else begin
            errors++;
            $error("[TB] FAIL %s digit observed %0d expected %0d", tag, dut.digit_q, exp_digit);
        end
    endtask

    // Drive one cycle of inputs, advance the model past the edge, then check
    task automatic applyStimulus(input logic r, input logic e, input int i,
                                 input logic b, input logic l, input string tag);
        rst_n     = r;
        en        = e;
        inp       = i[2:0];
        blank     = b;
        lamp_test = l;
        @(posedge clk);
        #1;
        if (!r) begin
            model_digit = 0;
            model_seg   = drive(7'h00);
        end else begin
            if (e) model_digit = i % 8;
            if (l)      model_seg = drive(7'h7F);
            else if (b) model_seg = drive(7'h00);
            else        model_seg = drive(glyphOf(model_digit));
        end
        checkOutput(tag);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_digit = 0;
        model_seg   = drive(7'h00);
        rst_n       = 1'b0;
        en          = 1'b0;
        inp         = 3'd0;
        blank       = 1'b0;
        lamp_test   = 1'b0;
        @(negedge clk);

        // Reset holds even with a load request pending
        applyStimulus(0, 1, 5, 0, 0, "reset_a");
        applyStimulus(0, 1, 5, 0, 0, "reset_b");
        applyStimulus(1, 0, 5, 0, 0, "reset_release");

        // Load every code on consecutive cycles
        for (int d = 0; d < 8; d++) begin
            applyStimulus(1, 1, d, 0, 0, $sformatf("sweep_%0d", d));
        end

        // Hold ignores inp while en is low
        applyStimulus(1, 1, 3, 0, 0, "hold_load");
        applyStimulus(1, 0, 6, 0, 0, "hold_a");
        applyStimulus(1, 0, 6, 0, 0, "hold_b");

        // Override priority and release without reload
        applyStimulus(1, 1, 2, 0, 0, "ovr_load");
        applyStimulus(1, 0, 7, 1, 0, "ovr_blank");
        applyStimulus(1, 0, 7, 1, 1, "ovr_lamp_over_blank");
        applyStimulus(1, 0, 7, 0, 1, "ovr_lamp_only");
        applyStimulus(1, 0, 7, 0, 0, "ovr_release");

        // Capture while blanked, shown once blank drops
        applyStimulus(1, 1, 4, 1, 0, "blank_capture");
        applyStimulus(1, 0, 1, 0, 0, "blank_release");

        // Mid-operation reset clears the captured digit
        applyStimulus(0, 0, 0, 0, 1, "mid_reset");
        applyStimulus(1, 0, 6, 0, 0, "after_mid_reset");

        // Randomized traffic including occasional resets and overrides
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 15) != 0),
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0),
                          $sformatf("rand_%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
